// File: rtl/overflow_range_store.sv
// overflow_range_store
//   Storage end of the heap-overflow tracking path in the execute stage.
//   Completed contiguous-store ranges [first,last] are kept in a DEPTH-entry
//   circular store. A range that overlaps the newest entry, or starts within
//   MERGE_GAP bytes past its end, is folded into that entry. Otherwise it
//   allocates a new entry, and the oldest entry is overwritten when the store
//   is full. Loads query the store combinationally. A registered debug port
//   exposes any single entry.
//
//   Optional feature macro: OVERFLOW_RANGE_HIT_CNT_EN. It adds an 8-bit
//   saturating hit counter per entry and the read_hits_o port.
//
// Ports
//   clk_i, rst_i      clock and synchronous active-high reset
//   clear_i           synchronous soft clear of every entry
//   en_write_i        push [addr_first_i, addr_last_i] this cycle
//   find_addr_i       lookup address
//   addr_in_range_o   combinational hit; hit_idx_o gives the lowest hitting entry
//   count_o, full_o   number of valid entries and the full flag
//   evict_o, drop_o   one-cycle pulses: oldest entry overwritten / malformed write
//   read_idx_i        debug entry select; read_first_o, read_last_o registered
//   read_hits_o       (feature only) registered hit count of the selected entry
module overflow_range_store #(
  parameter int DEPTH     = 8,
  parameter int AW        = 32,
  parameter int MERGE_GAP = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     en_write_i,
  input  logic [AW-1:0]            addr_first_i,
  input  logic [AW-1:0]            addr_last_i,
  input  logic [AW-1:0]            find_addr_i,
  output logic                     addr_in_range_o,
  output logic [$clog2(DEPTH)-1:0] hit_idx_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     evict_o,
  output logic                     drop_o,
  input  logic [$clog2(DEPTH)-1:0] read_idx_i,
  output logic [AW-1:0]            read_first_o,
  output logic [AW-1:0]            read_last_o
`ifdef OVERFLOW_RANGE_HIT_CNT_EN
  ,
  output logic [7:0]               read_hits_o
`endif
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam logic [AW:0]   GAP_W   = (AW+1)'(MERGE_GAP);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [AW-1:0]    r_first [DEPTH];
  logic [AW-1:0]    r_last  [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [IW-1:0]    r_wr_ptr;
  logic [IW-1:0]    r_newest;
  logic             r_newest_vld;
  logic [CW-1:0]    r_count;
  logic             r_full;
  logic             r_evict;
  logic             r_drop;
  logic [AW-1:0]    r_read_first;
  logic [AW-1:0]    r_read_last;

  logic [AW:0]      w_merge_lim;
  logic             w_can_merge;
  logic             w_do_drop;
  logic             w_do_merge;
  logic             w_do_alloc;
  logic [AW-1:0]    w_merge_first;
  logic [AW-1:0]    w_merge_last;
  logic [CW-1:0]    w_count_nxt;
  logic [DEPTH-1:0] w_match;
  logic             w_hit;
  logic [IW-1:0]    w_hit_idx;

  // Classify the incoming write as drop, merge or allocate. The merge limit
  // is computed one bit wider so that last+gap cannot wrap around.
  always_comb begin
    w_merge_lim   = {1'b0, r_last[r_newest]} + GAP_W;
    w_can_merge   = r_newest_vld && r_valid[r_newest] &&
                    ({1'b0, addr_first_i} <= w_merge_lim) &&
                    (addr_last_i >= r_first[r_newest]);
    w_merge_first = (addr_first_i < r_first[r_newest]) ? addr_first_i : r_first[r_newest];
    w_merge_last  = (addr_last_i  > r_last[r_newest])  ? addr_last_i  : r_last[r_newest];
    w_do_drop     = 1'b0;
    w_do_merge    = 1'b0;
    w_do_alloc    = 1'b0;
    if (en_write_i) begin
      if (addr_first_i > addr_last_i) begin
        w_do_drop = 1'b1;
      end else if (w_can_merge) begin
        w_do_merge = 1'b1;
      end else begin
        w_do_alloc = 1'b1;
      end
    end else begin
      w_do_alloc = 1'b0;
    end
    if (w_do_alloc && !r_full) begin
      w_count_nxt = r_count + CW'(1);
    end else begin
      w_count_nxt = r_count;
    end
  end

  // Lookup over registered contents only; scanning downward lets the lowest index win.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_match[i] = r_valid[i] && (find_addr_i >= r_first[i]) && (find_addr_i <= r_last[i]);
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_hit     = 1'b1;
        w_hit_idx = IW'(i);
      end else begin
        w_hit_idx = w_hit_idx;
      end
    end
  end

  // Control state, counters, pulses and the debug read registers.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_valid      <= '0;
      r_wr_ptr     <= '0;
      r_newest     <= '0;
      r_newest_vld <= 1'b0;
      r_count      <= '0;
      r_full       <= 1'b0;
      r_evict      <= 1'b0;
      r_drop       <= 1'b0;
      r_read_first <= '0;
      r_read_last  <= '0;
    end else begin
      r_evict      <= w_do_alloc && r_full;
      r_drop       <= w_do_drop;
      r_read_first <= r_valid[read_idx_i] ? r_first[read_idx_i] : '0;
      r_read_last  <= r_valid[read_idx_i] ? r_last[read_idx_i]  : '0;
      if (w_do_alloc) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_newest          <= r_wr_ptr;
        r_newest_vld      <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + IW'(1);
        r_count           <= w_count_nxt;
        r_full            <= (w_count_nxt == DEPTH_C);
      end else begin
        r_count <= r_count;
      end
    end
  end

  // Range bounds need no reset because the valid bits qualify them.
  always_ff @(posedge clk_i) begin
    if (w_do_merge && !rst_i && !clear_i) begin
      r_first[r_newest] <= w_merge_first;
      r_last[r_newest]  <= w_merge_last;
    end else if (w_do_alloc && !rst_i && !clear_i) begin
      r_first[r_wr_ptr] <= addr_first_i;
      r_last[r_wr_ptr]  <= addr_last_i;
    end else begin
      r_first[r_wr_ptr] <= r_first[r_wr_ptr];
    end
  end

`ifdef OVERFLOW_RANGE_HIT_CNT_EN
  logic [7:0] r_hits [DEPTH];
  logic [7:0] r_read_hits;

  // Saturating per-entry hit counters. Allocation restarts the slot's count,
  // while a merge leaves it untouched.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst_i || clear_i) begin
        r_hits[i] <= 8'd0;
      end else if (w_do_alloc && (r_wr_ptr == IW'(i))) begin
        r_hits[i] <= 8'd0;
      end else if (w_hit && (w_hit_idx == IW'(i)) && (r_hits[i] != 8'hFF)) begin
        r_hits[i] <= r_hits[i] + 8'd1;
      end else begin
        r_hits[i] <= r_hits[i];
      end
    end
  end

  // Debug copy of the selected entry's hit count.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      r_read_hits <= 8'd0;
    end else begin
      r_read_hits <= r_valid[read_idx_i] ? r_hits[read_idx_i] : 8'd0;
    end
  end

  assign read_hits_o = r_read_hits;
`endif

  assign addr_in_range_o = w_hit;
  assign hit_idx_o       = w_hit_idx;
  assign count_o         = r_count;
  assign full_o          = r_full;
  assign evict_o         = r_evict;
  assign drop_o          = r_drop;
  assign read_first_o    = r_read_first;
  assign read_last_o     = r_read_last;

endmodule

// File: tb/tb_overflow_range_store.sv
// Directed testbench for overflow_range_store (DEPTH=8, AW=32, MERGE_GAP=4).
module tb_overflow_range_store;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        clear_i = 1'b0;
  logic        en_write_i = 1'b0;
  logic [31:0] addr_first_i = 32'd0;
  logic [31:0] addr_last_i = 32'd0;
  logic [31:0] find_addr_i = 32'd0;
  logic        addr_in_range_o;
  logic [2:0]  hit_idx_o;
  logic [3:0]  count_o;
  logic        full_o;
  logic        evict_o;
  logic        drop_o;
  logic [2:0]  read_idx_i = 3'd0;
  logic [31:0] read_first_o;
  logic [31:0] read_last_o;
`ifdef OVERFLOW_RANGE_HIT_CNT_EN
  logic [7:0]  read_hits_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  overflow_range_store #(.DEPTH(8), .AW(32), .MERGE_GAP(4)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .en_write_i(en_write_i),
    .addr_first_i(addr_first_i), .addr_last_i(addr_last_i), .find_addr_i(find_addr_i),
    .addr_in_range_o(addr_in_range_o), .hit_idx_o(hit_idx_o), .count_o(count_o),
    .full_o(full_o), .evict_o(evict_o), .drop_o(drop_o), .read_idx_i(read_idx_i),
    .read_first_o(read_first_o), .read_last_o(read_last_o)
`ifdef OVERFLOW_RANGE_HIT_CNT_EN
    , .read_hits_o(read_hits_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
  endtask

  task automatic wr(input logic [31:0] f, input logic [31:0] l);
    en_write_i   = 1'b1;
    addr_first_i = f;
    addr_last_i  = l;
    step();
    en_write_i   = 1'b0;
  endtask

  task automatic query(input logic [31:0] a);
    find_addr_i = a;
    #1;
  endtask

  initial begin
    #1;
    // Reset state
    do_reset();
    query(32'h0);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_full", 64'(full_o), 64'd0);
    chk("rst_evict", 64'(evict_o), 64'd0);
    chk("rst_drop", 64'(drop_o), 64'd0);
    chk("rst_rfirst", 64'(read_first_o), 64'd0);
    chk("rst_rlast", 64'(read_last_o), 64'd0);
    chk("rst_hit", 64'(addr_in_range_o), 64'd0);
    chk("rst_hidx", 64'(hit_idx_o), 64'd0);

    // Basic write and inclusive bounds
    wr(32'h1000, 32'h1020);
    query(32'h1020);
    chk("t1_hit_last", 64'(addr_in_range_o), 64'd1);
    chk("t1_hidx", 64'(hit_idx_o), 64'd0);
    chk("t1_count", 64'(count_o), 64'd1);
    query(32'h1000);
    chk("t1_hit_first", 64'(addr_in_range_o), 64'd1);
    query(32'h1021);
    chk("t1_miss_above", 64'(addr_in_range_o), 64'd0);
    query(32'h0FFF);
    chk("t1_miss_below", 64'(addr_in_range_o), 64'd0);

    // Merge with a 4-byte gap, then allocations
    do_reset();
    wr(32'h2000, 32'h2010);
    wr(32'h2014, 32'h2030);
    chk("t2_merge_count", 64'(count_o), 64'd1);
    read_idx_i = 3'd0;
    step();
    chk("t2_rfirst", 64'(read_first_o), 64'h2000);
    chk("t2_rlast", 64'(read_last_o), 64'h2030);
    wr(32'h2040, 32'h2050);
    chk("t2_alloc_count", 64'(count_o), 64'd2);
    wr(32'h2055, 32'h2060);
    chk("t2_gap5_count", 64'(count_o), 64'd3);
    query(32'h2058);
    chk("t2_hidx2", 64'(hit_idx_o), 64'd2);

    // Fill, then wrap with eviction
    do_reset();
    for (int k = 0; k < 8; k++) begin
      wr(32'(k * 32'h100), 32'(k * 32'h100 + 32'h10));
      chk("t3_no_evict", 64'(evict_o), 64'd0);
    end
    chk("t3_full8", 64'(full_o), 64'd1);
    chk("t3_count8", 64'(count_o), 64'd8);
    wr(32'h800, 32'h810);
    chk("t3_evict", 64'(evict_o), 64'd1);
    chk("t3_full", 64'(full_o), 64'd1);
    chk("t3_count", 64'(count_o), 64'd8);
    query(32'h0);
    chk("t3_miss_old", 64'(addr_in_range_o), 64'd0);
    query(32'h800);
    chk("t3_hit_new", 64'(addr_in_range_o), 64'd1);
    chk("t3_hidx_new", 64'(hit_idx_o), 64'd0);
    query(32'h110);
    chk("t3_hidx1", 64'(hit_idx_o), 64'd1);
    step();
    chk("t3_evict_once", 64'(evict_o), 64'd0);

    // Malformed range dropped
    wr(32'h3010, 32'h3000);
    chk("t4_drop", 64'(drop_o), 64'd1);
    chk("t4_count", 64'(count_o), 64'd8);
    query(32'h3008);
    chk("t4_no_hit", 64'(addr_in_range_o), 64'd0);
    step();
    chk("t4_drop_once", 64'(drop_o), 64'd0);

    // Same-cycle write and query, then clear beats write
    do_reset();
    en_write_i   = 1'b1;
    addr_first_i = 32'h4000;
    addr_last_i  = 32'h4010;
    query(32'h4008);
    chk("t5_same_cycle", 64'(addr_in_range_o), 64'd0);
    @(posedge clk_i);
    #1;
    en_write_i = 1'b0;
    query(32'h4008);
    chk("t5_next_cycle", 64'(addr_in_range_o), 64'd1);
    clear_i      = 1'b1;
    en_write_i   = 1'b1;
    addr_first_i = 32'h5000;
    addr_last_i  = 32'h5010;
    step();
    clear_i    = 1'b0;
    en_write_i = 1'b0;
    query(32'h4008);
    chk("t5_clr_count", 64'(count_o), 64'd0);
    chk("t5_clr_hit", 64'(addr_in_range_o), 64'd0);
    chk("t5_clr_drop", 64'(drop_o), 64'd0);
    query(32'h5008);
    chk("t5_clr_wr_lost", 64'(addr_in_range_o), 64'd0);
    read_idx_i = 3'd3;
    step();
    chk("t5_inv_rlast", 64'(read_last_o), 64'd0);

`ifdef OVERFLOW_RANGE_HIT_CNT_EN
    // Saturating hit counter and re-allocation
    do_reset();
    read_idx_i = 3'd0;
    wr(32'h100, 32'h1FF);
    query(32'h150);
    repeat (300) step();
    query(32'h0);
    step();
    chk("hc_saturate", 64'(read_hits_o), 64'd255);
    for (int k = 1; k <= 8; k++) begin
      wr(32'(k * 32'h10000), 32'(k * 32'h10000 + 32'h10));
    end
    step();
    chk("hc_realloc_first", 64'(read_first_o), 64'h80000);
    chk("hc_realloc_hits", 64'(read_hits_o), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/overflow_range_store.md
Name: overflow_range_store

Overview:
- Storage end of the heap-overflow tracking interface in the execute stage.
- The branch unit's store-run tracker pushes completed contiguous-store ranges [first,last]. This block keeps them in a DEPTH-entry circular store.
- It answers same-cycle "address inside any recorded range" queries for loads.
- It provides a registered debug read port for the user-visible probe path.

Parameters:
- DEPTH, 8, number of range entries; power of two, 2..32.
- AW, 32, address width of range bounds and query address.
- MERGE_GAP, 4, max byte gap for a new range to be merged into the newest entry instead of allocating.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- clear_i  in  1  soft clear of all entries (user/debug), synchronous
- en_write_i  in  1  push range this cycle
- addr_first_i  in  AW  range start, inclusive
- addr_last_i  in  AW  range end, inclusive
- find_addr_i  in  AW  lookup address
- addr_in_range_o  out  1  combinational hit on find_addr_i
- hit_idx_o  out  $clog2(DEPTH)  lowest-index hitting entry; 0 when no hit
- count_o  out  $clog2(DEPTH)+1  valid entries
- full_o  out  1  count_o == DEPTH
- evict_o  out  1  one-cycle pulse: oldest entry overwritten
- drop_o  out  1  one-cycle pulse: malformed write rejected
- read_idx_i  in  $clog2(DEPTH)  debug entry select
- read_first_o  out  AW  registered first bound of selected entry
- read_last_o  out  AW  registered last bound of selected entry (0 if invalid)

Behaviour:
- Reset (rst_i=1 at clk edge):
  - All valid bits 0 and write pointer wr_ptr=0.
  - Newest pointer invalid.
  - count_o=0, full_o=0, evict_o=0, drop_o=0.
  - read_first_o=0, read_last_o=0.
  - addr_in_range_o=0 (no valid entries), hit_idx_o=0.
- clear_i:
  - Same effect as reset on entries, pointers and counters.
  - Debug read registers also go to 0.
  - clear_i beats en_write_i in the same cycle; the write is discarded without a drop_o pulse.
- Write acceptance: en_write_i=1, no reset/clear. Evaluated in this order:
  1. Malformed range, addr_first_i > addr_last_i (unsigned): no state change, drop_o=1 next cycle.
  2. Merge: newest entry valid and addr_first_i <= newest.last + MERGE_GAP (no AW overflow; compute in AW+1 bits) and addr_last_i >= newest.first. Newest.first becomes min of the two firsts, newest.last becomes max of the two lasts. No allocation; count unchanged.
  3. Allocate: entry[wr_ptr] is written valid and becomes newest; wr_ptr increments mod DEPTH (DEPTH-1 wraps to 0).
     - If count < DEPTH, count increments.
     - If full, the oldest entry (entry at wr_ptr) is overwritten, count stays DEPTH and evict_o=1 next cycle.
- Writes are accepted every cycle. There is no backpressure.
- Lookup is purely combinational over current registered contents:
  - Hit when valid and first <= find_addr_i <= last, unsigned, inclusive.
  - A write in cycle N is visible to lookups from cycle N+1 onward. A same-cycle write never affects the lookup.
  - Multiple hits: hit_idx_o = lowest index.
- Debug read: read_first_o/read_last_o reflect entry[read_idx_i] one cycle after read_idx_i is applied, sampled from pre-write contents. An invalid entry reads as 0/0.
- Pulses: evict_o and drop_o are registered, high for exactly one cycle per event.
- Simultaneous write of a new range and query of the same address: no hit that cycle, hit next cycle.

Optional Feature:
- Macro: OVERFLOW_RANGE_HIT_CNT_EN.
- When defined:
  - Each entry holds an 8-bit saturating hit counter, incremented on every cycle its range is the reported hit (hit_idx_o entry).
  - The counter is zeroed on allocate, reset and clear; merge keeps it.
  - Extra port read_hits_o (out, 8) is registered alongside read_first_o, and is 0 for an invalid entry.
- When undefined: no counters and no read_hits_o port. All other behaviour is identical.

Test Plan:
- Reset, then write [0x1000,0x1020]. Query 0x1020 next cycle gives addr_in_range_o=1, hit_idx_o=0, count_o=1. Query 0x1021 gives 0.
- Write [0x2000,0x2010] then [0x2014,0x2030] (gap 4). count_o stays 1 and read_idx_i=0 gives 0x2000/0x2030. Write [0x2040,0x2050] then allocates, count_o=2.
- DEPTH=8: write 9 disjoint ranges, range k = [0x100*k, 0x100*k+0x10]. On the 9th, evict_o pulses once, full_o=1, query 0x0 misses, query 0x800 hits with hit_idx_o=0.
- Write [0x3010,0x3000] gives drop_o=1 for one cycle, count_o unchanged, no hit at 0x3008.
- Same cycle: en_write_i=1 with [0x4000,0x4010], find_addr_i=0x4008 gives 0. Next cycle it gives 1. Then clear_i together with another write gives count_o=0, no hits, drop_o=0.
- With OVERFLOW_RANGE_HIT_CNT_EN: 300 consecutive hit cycles on entry 0 make read_hits_o read 255 (saturated). Re-allocating that slot reads 0.
